// File: rtl/tank_pkg.sv
// Shared tank-game definitions: bullet record layout, player ids and bullet-pool FSM states.
package tank_pkg;

  localparam int ACTIVE_BIT = 28;
  localparam int X_MSB      = 27;
  localparam int X_LSB      = 18;
  localparam int Y_MSB      = 17;
  localparam int Y_LSB      = 8;
  localparam int DIR_MSB    = 7;
  localparam int DIR_LSB    = 6;
  localparam int OWNER_BIT  = 5;

  typedef enum logic {P1 = 1'b0, P2 = 1'b1} player_e;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    HALT  = 2'd1,
    RUN   = 2'd2
  } pool_state_e;

  // Field order mirrors the bit offsets above; unused bits stay zero.
  typedef struct packed {
    logic [2:0] rsvd_hi;
    logic       active;
    logic [9:0] x;
    logic [9:0] y;
    logic [1:0] dir;
    logic       owner;
    logic [4:0] rsvd_lo;
  } bullet_rec_t;

endpackage

// File: rtl/slot_prio_enc.sv
// Lowest-index set bit finder over the free-slot mask, plus an any-free flag.
module slot_prio_enc #(
  parameter int N = 16,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] free_mask,
  output logic [W-1:0] idx,
  output logic         any_free
);

  always_comb begin
    idx      = '0;
    any_free = |free_mask;
    // Scan downward so the lowest free index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (free_mask[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/bullet_pool_arbiter.sv
// Shared bullet-slot pool: arbitrates player fire requests, tracks occupancy and drives the bullet RAM port.
// state | meaning
// CLEAR | zero-write sweep over every slot, pool state held empty
// HALT  | game off, pool idle and empty
// RUN   | grants, frees and cooldowns active
module bullet_pool_arbiter
  import tank_pkg::*;
#(
  parameter  int MAX_BULLETS = 8,
  parameter  int COOLDOWN    = 4,
  localparam int NUM_SLOTS   = 2 * MAX_BULLETS,
  localparam int SLOT_W      = $clog2(NUM_SLOTS),
  localparam int CNT_W       = $clog2(MAX_BULLETS + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 game_on,
  input  logic                 frame_tick,
  input  logic [1:0]           fire_req,
  input  logic [1:0][9:0]      spawn_x,
  input  logic [1:0][9:0]      spawn_y,
  input  logic [1:0][1:0]      spawn_dir,
  input  logic                 free_valid,
  input  logic [SLOT_W-1:0]    free_slot,
  output logic [1:0]           fire_grant,
  output logic                 wr_valid,
  output logic [SLOT_W-1:0]    wr_slot,
  output logic [31:0]          wr_data,
  output logic [NUM_SLOTS-1:0] slot_busy,
  output logic [CNT_W-1:0]     count_p1,
  output logic [CNT_W-1:0]     count_p2
);

  localparam int CD_W = $clog2(COOLDOWN + 1);

  pool_state_e            state_q, state_d;
  logic [SLOT_W-1:0]      clr_idx_q;
  logic [NUM_SLOTS-1:0]   busy_q, busy_d, owner_q, owner_d;
  logic [1:0][CNT_W-1:0]  count_q, count_d;
  logic [1:0][CD_W-1:0]   cd_q, cd_d;
  player_e                rr_q;
  logic                   pend_valid_q, pend_valid_d;
  logic [SLOT_W-1:0]      pend_slot_q, pend_slot_d;
  logic                   wr_valid_d;
  logic [SLOT_W-1:0]      wr_slot_d;
  bullet_rec_t            wr_rec_q, wr_rec_d;
  logic [1:0]             grant_d;

  logic [SLOT_W-1:0]      free_idx;
  logic                   any_free;
  logic                   run;
  logic [1:0]             elig;
  logic                   grant_any;
  player_e                gnt_p;
  logic                   free_ok;

  slot_prio_enc #(.N(NUM_SLOTS), .W(SLOT_W)) u_prio (
    .free_mask (~busy_q),
    .idx       (free_idx),
    .any_free  (any_free)
  );

  always_comb begin
    run = (state_q == RUN) && game_on;
    for (int p = 0; p < 2; p++) begin
      // A pending deferred free owns the write port this cycle, so grants stall.
      elig[p] = run && !pend_valid_q && fire_req[p] && (cd_q[p] == '0) &&
                (count_q[p] < CNT_W'(MAX_BULLETS)) && any_free;
    end
    grant_any = |elig;
    gnt_p     = rr_q;
    if (elig == 2'b01)      gnt_p = P1;
    else if (elig == 2'b10) gnt_p = P2;
    free_ok = run && free_valid && busy_q[free_slot];
    grant_d = grant_any ? ((gnt_p == P1) ? 2'b01 : 2'b10) : 2'b00;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CLEAR:   if (clr_idx_q == SLOT_W'(NUM_SLOTS - 1)) state_d = game_on ? RUN : HALT;
      HALT:    if (game_on) state_d = RUN;
      RUN:     if (!game_on) state_d = CLEAR;
      default: state_d = CLEAR;
    endcase
  end

  always_comb begin
    wr_valid_d   = 1'b0;
    wr_slot_d    = '0;
    wr_rec_d     = '0;
    pend_valid_d = 1'b0;
    pend_slot_d  = pend_slot_q;
    if (state_q == CLEAR) begin
      wr_valid_d = 1'b1;
      wr_slot_d  = clr_idx_q;
    end else if (run) begin
      if (grant_any) begin
        wr_valid_d      = 1'b1;
        wr_slot_d       = free_idx;
        wr_rec_d.active = 1'b1;
        wr_rec_d.x      = spawn_x[gnt_p];
        wr_rec_d.y      = spawn_y[gnt_p];
        wr_rec_d.dir    = spawn_dir[gnt_p];
        wr_rec_d.owner  = gnt_p;
        if (free_ok) begin
          pend_valid_d = 1'b1;
          pend_slot_d  = free_slot;
        end
      end else if (pend_valid_q) begin
        wr_valid_d = 1'b1;
        wr_slot_d  = pend_slot_q;
        if (free_ok) begin
          pend_valid_d = 1'b1;
          pend_slot_d  = free_slot;
        end
      end else if (free_ok) begin
        wr_valid_d = 1'b1;
        wr_slot_d  = free_slot;
      end
    end
  end

  always_comb begin
    busy_d  = busy_q;
    owner_d = owner_q;
    count_d = count_q;
    cd_d    = cd_q;
    if (state_q != RUN) begin
      busy_d  = '0;
      count_d = '0;
      cd_d    = '0;
    end else if (run) begin
      for (int p = 0; p < 2; p++) begin
        if (frame_tick && (cd_q[p] != '0)) cd_d[p] = cd_q[p] - CD_W'(1);
      end
      if (free_ok) begin
        busy_d[free_slot] = 1'b0;
        count_d[owner_q[free_slot]] = count_d[owner_q[free_slot]] - CNT_W'(1);
      end
      // Grant is applied last so its cooldown load overrides a same-cycle tick.
      if (grant_any) begin
        busy_d[free_idx]  = 1'b1;
        owner_d[free_idx] = gnt_p;
        count_d[gnt_p]    = count_d[gnt_p] + CNT_W'(1);
        cd_d[gnt_p]       = CD_W'(COOLDOWN);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= CLEAR;
      clr_idx_q    <= '0;
      busy_q       <= '0;
      owner_q      <= '0;
      count_q      <= '0;
      cd_q         <= '0;
      rr_q         <= P1;
      pend_valid_q <= 1'b0;
      pend_slot_q  <= '0;
      wr_valid     <= 1'b0;
      wr_slot      <= '0;
      wr_rec_q     <= '0;
      fire_grant   <= 2'b00;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= ((state_q == CLEAR) && (clr_idx_q != SLOT_W'(NUM_SLOTS - 1))) ?
                      clr_idx_q + SLOT_W'(1) : '0;
      busy_q       <= busy_d;
      owner_q      <= owner_d;
      count_q      <= count_d;
      cd_q         <= cd_d;
      if (elig == 2'b11) rr_q <= (rr_q == P1) ? P2 : P1;
      pend_valid_q <= pend_valid_d;
      pend_slot_q  <= pend_slot_d;
      wr_valid     <= wr_valid_d;
      wr_slot      <= wr_slot_d;
      wr_rec_q     <= wr_rec_d;
      fire_grant   <= grant_d;
    end
  end

  assign wr_data   = wr_rec_q;
  assign slot_busy = busy_q;
  assign count_p1  = count_q[0];
  assign count_p2  = count_q[1];

  count_bound_a: assert property (@(posedge clk) disable iff (!reset)
    (count_q[0] <= CNT_W'(MAX_BULLETS)) && (count_q[1] <= CNT_W'(MAX_BULLETS)));

  count_underflow_a: assert property (@(posedge clk) disable iff (!reset)
    free_ok |-> (count_q[owner_q[free_slot]] != '0));

endmodule
